register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/regfile_pkg.sv | 34 +++
 rtl/reg_scoreboard.sv | 91 +++++++++
 rtl/register_file.sv | 90 +++++++++
 tb/tb_register_file.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared defaults and types for the integer register file and its scoreboard.
//   XLEN_DEF     : register data width
//   NUM_REGS_DEF : number of architectural integer registers
//   ADDR_W_DEF   : register index width, clog2(NUM_REGS_DEF)
//   sb_op_e      : per-entry busy-bit update selected each cycle
//   sb_next      : applies an sb_op_e to a busy bit
// Used by register_file and reg_scoreboard.
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN_DEF     = 64;
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;

  typedef enum logic [1:0] {
    SB_HOLD  = 2'd0,
    SB_SET   = 2'd1,
    SB_CLEAR = 2'd2
  } sb_op_e;

  function automatic logic sb_next(input sb_op_e op, input logic cur);
    logic nxt;
    nxt = cur;
    case (op)
      SB_SET:   nxt = 1'b1;
      SB_CLEAR: nxt = 1'b0;
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Busy-bit array tracking registers that have an issued but not yet written
// producer. Issue sets a bit, writeback clears it; when both hit the same
// entry on one edge the set wins because it belongs to the newer producer.
// Entry 0 is never set and always reads as not busy.
//
// Optional feature: define REGFILE_BYPASS_EN to forward the writeback clear
// onto the busy outputs in the same cycle (an issue to the same index in that
// cycle keeps the output busy).
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   issue_valid, issue_reg  : set request from decode
//   clear_valid, clear_reg  : clear request from write-back
//   read_reg1, read_reg2    : lookup indices
//   busy1, busy2            : busy state of read_reg1 / read_reg2
// -----------------------------------------------------------------------------
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic              clear_valid,
  input  logic [ADDR_W-1:0] clear_reg,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic              busy1,
  output logic              busy2
);

  logic [NUM_REGS-1:0] busy_q;
  sb_op_e              op [NUM_REGS];
  logic                stored1;
  logic                stored2;

  // Per-entry update selection; set is checked first so it wins a tie.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      op[i] = SB_HOLD;
      if (i != 0) begin
        if (issue_valid && (issue_reg == ADDR_W'(i))) begin
          op[i] = SB_SET;
        end else if (clear_valid && (clear_reg == ADDR_W'(i))) begin
          op[i] = SB_CLEAR;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        busy_q[i] <= sb_next(op[i], busy_q[i]);
      end
    end
  end

  // Index 0 is gated so it reads idle even before the first reset.
  always_comb begin
    stored1 = (read_reg1 != '0) && busy_q[read_reg1];
    stored2 = (read_reg2 != '0) && busy_q[read_reg2];
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_hit1;
  logic wr_hit2;

  always_comb begin
    wr_hit1 = clear_valid && (clear_reg != '0) && (clear_reg == read_reg1);
    wr_hit2 = clear_valid && (clear_reg != '0) && (clear_reg == read_reg2);
    // On a writeback hit the stored bit is stale: the result is "busy" only
    // if a new producer is being issued to the same index right now.
    busy1 = wr_hit1 ? (issue_valid && (issue_reg == read_reg1)) : stored1;
    busy2 = wr_hit2 ? (issue_valid && (issue_reg == read_reg2)) : stored2;
  end
`else
  always_comb begin
    busy1 = stored1;
    busy2 = stored2;
  end
`endif

endmodule

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// Integer register file with two combinational read ports, one single-cycle
// write port and a busy-bit scoreboard (reg_scoreboard) for hazard detection.
// Register 0 is hard-wired to zero; writes and issues to it are dropped.
//
// Optional feature: define REGFILE_BYPASS_EN to forward write_data onto a read
// port whose index matches the write in the same cycle.
//
// Ports
//   clk, reset                          : clock, synchronous active-high reset
//   read_reg1/2 -> read_data1/2         : combinational register reads
//   busy1/2                             : outstanding producer for read_reg1/2
//   write_enable, write_reg, write_data : writeback port, always accepted
//   issue_valid, issue_reg              : destination of a newly issued op
// -----------------------------------------------------------------------------
module register_file
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [XLEN-1:0]   read_data1,
  output logic [XLEN-1:0]   read_data2,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [XLEN-1:0]   write_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              busy1,
  output logic              busy2
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wr_live;
  logic [XLEN-1:0] stored1;
  logic [XLEN-1:0] stored2;

  assign wr_live = write_enable && (write_reg != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[write_reg] <= write_data;
    end
  end

  // Index 0 is muxed to zero rather than relying on the stored entry.
  always_comb begin
    stored1 = (read_reg1 == '0) ? '0 : regs[read_reg1];
    stored2 = (read_reg2 == '0) ? '0 : regs[read_reg2];
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    read_data1 = (wr_live && (write_reg == read_reg1)) ? write_data : stored1;
    read_data2 = (wr_live && (write_reg == read_reg2)) ? write_data : stored2;
  end
`else
  always_comb begin
    read_data1 = stored1;
    read_data2 = stored2;
  end
`endif

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .clear_valid (write_enable),
    .clear_reg   (write_reg),
    .read_reg1   (read_reg1),
    .read_reg2   (read_reg2),
    .busy1       (busy1),
    .busy2       (busy2)
  );

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Table-driven bench for register_file. Each row drives one cycle of inputs
// and carries the expected read-port outputs for that cycle (separate columns
// for builds with and without REGFILE_BYPASS_EN). Expected values are queued
// when a row is driven and popped when the outputs are sampled just before
// the next rising edge.
// -----------------------------------------------------------------------------
module tb_register_file;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            reset;
  logic [AW-1:0]   read_reg1;
  logic [AW-1:0]   read_reg2;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;
  logic            write_enable;
  logic [AW-1:0]   write_reg;
  logic [XLEN-1:0] write_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_reg;
  logic            busy1;
  logic            busy2;

  register_file #(
    .XLEN     (XLEN),
    .NUM_REGS (NREG),
    .ADDR_W   (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .read_reg1    (read_reg1),
    .read_reg2    (read_reg2),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .issue_valid  (issue_valid),
    .issue_reg    (issue_reg),
    .busy1        (busy1),
    .busy2        (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            rst;
    logic            we;
    logic [AW-1:0]   wr;
    logic [XLEN-1:0] wd;
    logic            iv;
    logic [AW-1:0]   ir;
    logic [AW-1:0]   r1;
    logic [AW-1:0]   r2;
    logic            chk;
    logic [XLEN-1:0] d1;
    logic            b1;
    logic [XLEN-1:0] d2;
    logic            b2;
  } vec_t;

  typedef struct {
    string           name;
    logic [XLEN-1:0] d1;
    logic            b1;
    logic [XLEN-1:0] d2;
    logic            b2;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  // Row builder: nd*/nb* are stored-state expectations, bd*/bb* forwarded.
  task automatic add(input string nm, input logic rst, input logic we,
                     input logic [AW-1:0] wr, input logic [XLEN-1:0] wd,
                     input logic iv, input logic [AW-1:0] ir,
                     input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                     input logic chk,
                     input logic [XLEN-1:0] nd1, input logic nb1,
                     input logic [XLEN-1:0] nd2, input logic nb2,
                     input logic [XLEN-1:0] bd1, input logic bb1,
                     input logic [XLEN-1:0] bd2, input logic bb2);
    vec_t v;
    v.name = nm; v.rst = rst; v.we = we; v.wr = wr; v.wd = wd;
    v.iv = iv; v.ir = ir; v.r1 = r1; v.r2 = r2; v.chk = chk;
`ifdef REGFILE_BYPASS_EN
    v.d1 = bd1; v.b1 = bb1; v.d2 = bd2; v.b2 = bb2;
`else
    v.d1 = nd1; v.b1 = nb1; v.d2 = nd2; v.b2 = nb2;
`endif
    vecs.push_back(v);
  endtask

  task automatic cmp_d(input string nm, input string fld,
                       input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
    end
  endtask

  task automatic cmp_b(input string nm, input string fld,
                       input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %b, expected %b", nm, fld, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset        = v.rst;
    write_enable = v.we;
    write_reg    = v.wr;
    write_data   = v.wd;
    issue_valid  = v.iv;
    issue_reg    = v.ir;
    read_reg1    = v.r1;
    read_reg2    = v.r2;
    if (v.chk) begin
      e.name = v.name; e.d1 = v.d1; e.b1 = v.b1; e.d2 = v.d2; e.b2 = v.b2;
      exp_q.push_back(e);
    end
  endtask

  task automatic sample();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: queue empty at sample, got 0 entries, expected 1");
      return;
    end
    e = exp_q.pop_front();
    cmp_d(e.name, "read_data1", read_data1, e.d1);
    cmp_b(e.name, "busy1",      busy1,      e.b1);
    cmp_d(e.name, "read_data2", read_data2, e.d2);
    cmp_b(e.name, "busy2",      busy2,      e.b2);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; write_enable = 1'b0; write_reg = '0; write_data = '0;
    issue_valid = 1'b0; issue_reg = '0; read_reg1 = '0; read_reg2 = '0;

    //  name       rst we wr  wd                       iv ir  r1  r2 chk  no-bypass: d1 b1 d2 b2        bypass: d1 b1 d2 b2
    add("rst_wi",   1, 1, 2,  64'h99,                  1, 8,  5,  31, 0,  0, 0, 0, 0,                    0, 0, 0, 0);
    add("rst_drop", 0, 0, 0,  0,                       0, 0,  2,  8,  1,  0, 0, 0, 0,                    0, 0, 0, 0);
    add("rst_rd",   0, 0, 0,  0,                       0, 0,  5,  31, 1,  0, 0, 0, 0,                    0, 0, 0, 0);
    add("wr_x7",    0, 1, 7,  64'hDEAD_BEEF_0000_0001, 0, 0,  7,  0,  1,  0, 0, 0, 0,
        64'hDEAD_BEEF_0000_0001, 0, 0, 0);
    add("wr_x0",    0, 1, 0,  64'hFFFF,                0, 0,  7,  0,  1,  64'hDEAD_BEEF_0000_0001, 0, 0, 0,
        64'hDEAD_BEEF_0000_0001, 0, 0, 0);
    add("rd_x0",    0, 0, 0,  0,                       0, 0,  0,  0,  1,  0, 0, 0, 0,                    0, 0, 0, 0);
    add("iss_x3",   0, 0, 0,  0,                       1, 3,  3,  7,  1,  0, 0, 64'hDEAD_BEEF_0000_0001, 0,
        0, 0, 64'hDEAD_BEEF_0000_0001, 0);
    add("wr_x3",    0, 1, 3,  64'h42,                  0, 0,  3,  3,  1,  0, 1, 0, 1,                    64'h42, 0, 64'h42, 0);
    add("rd_x3",    0, 0, 0,  0,                       0, 0,  3,  3,  1,  64'h42, 0, 64'h42, 0,          64'h42, 0, 64'h42, 0);
    add("iw_x9",    0, 1, 9,  64'h10,                  1, 9,  9,  9,  1,  0, 0, 0, 0,                    64'h10, 1, 64'h10, 1);
    add("rd_x9",    0, 0, 0,  0,                       1, 6,  9,  9,  1,  64'h10, 1, 64'h10, 1,          64'h10, 1, 64'h10, 1);
    add("i4_w6",    0, 1, 6,  64'h66,                  1, 4,  4,  6,  1,  0, 0, 0, 1,                    0, 0, 64'h66, 0);
    add("rd_4_6",   0, 0, 0,  0,                       0, 0,  4,  6,  1,  0, 1, 64'h66, 0,               0, 1, 64'h66, 0);
    add("byp_x12",  0, 1, 12, 64'h55,                  0, 0,  4,  12, 1,  0, 1, 0, 0,                    0, 1, 64'h55, 0);
    add("rd_x12",   0, 0, 0,  0,                       0, 0,  12, 12, 1,  64'h55, 0, 64'h55, 0,          64'h55, 0, 64'h55, 0);
    add("iss_x0",   0, 0, 0,  0,                       1, 0,  0,  12, 1,  0, 0, 64'h55, 0,               0, 0, 64'h55, 0);
    add("rd_x0b",   0, 0, 0,  0,                       0, 0,  0,  9,  1,  0, 0, 64'h10, 1,               0, 0, 64'h10, 1);
    add("rst2",     1, 1, 2,  64'h99,                  1, 8,  7,  4,  0,  0, 0, 0, 0,                    0, 0, 0, 0);
    add("rst2_a",   0, 0, 0,  0,                       0, 0,  7,  4,  1,  0, 0, 0, 0,                    0, 0, 0, 0);
    add("rst2_b",   0, 0, 0,  0,                       0, 0,  2,  8,  1,  0, 0, 0, 0,                    0, 0, 0, 0);
    add("rst2_c",   0, 0, 0,  0,                       0, 0,  9,  3,  1,  0, 0, 0, 0,                    0, 0, 0, 0);

    // Long-latency producer: busy must persist across idle cycles until the
    // writeback arrives.
    add("lat_iss",  0, 0, 0,  0,                       1, 20, 20, 20, 1,  0, 0, 0, 0,                    0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      add("lat_hold", 0, 0, 0, 0,                      0, 0,  20, 20, 1,  0, 1, 0, 1,                    0, 1, 0, 1);
    end
    add("lat_wr",   0, 1, 20, 64'hABC,                 0, 0,  20, 21, 1,  0, 1, 0, 0,                    64'hABC, 0, 0, 0);
    add("lat_done", 0, 0, 0,  0,                       0, 0,  20, 21, 1,  64'hABC, 0, 0, 0,              64'hABC, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #4;
      if (vecs[i].chk) sample();
    end

    @(negedge clk);
    reset = 1'b0; write_enable = 1'b0; issue_valid = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
